// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and helpers for the two-master data RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_ram_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_DONE  = 2'd2
   } arb_state_e;

   // True when every address bit at or above win_bits is zero.
   function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                           input int unsigned        win_bits);
      logic [ADDR_W-1:0] hi;
      hi = addr >> win_bits;
      return (hi == '0);
   endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// One requester's port onto the data RAM arbiter: request fields in, response out.
// Latency: n/a (wires only).
// Backpressure: req and its fields are held by the master until ready pulses.
// Ports: req/we/sel/addr/wdata from master; rdata/ready/err from arbiter.
interface data_ram_arbiter_if;
   import data_ram_arbiter_pkg::*;

   logic              req;
   logic              we;
   logic [SEL_W-1:0]  sel;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              err;

   modport master (output req, we, sel, addr, wdata,
                   input  rdata, ready, err);

   modport slave  (input  req, we, sel, addr, wdata,
                   output rdata, ready, err);
endinterface

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// Two-way request picker: one-hot grant from req, previous winner and priority mode.
// Latency: combinational.
// Backpressure: none; a lone request always wins, a tie goes to the non-previous winner.
// Ports: req[1:0], last_grant, fixed_prio in; grant[1:0] one-hot (or zero) out.
module data_ram_arbiter_rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       fixed_prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      // Tie: M0 if it has fixed priority or if M1 was served last.
      if (req == 2'b11) begin
         grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one data RAM port between M0 (CPU) and M1 (loader), one access at a time.
// Latency: IDLE -> ISSUE -> DONE; ready pulses two edges after req is sampled, 3 cycles/access.
// Backpressure: losing master keeps req asserted and waits; requests are never dropped.
// Ports: clk, rst (sync, active-high); m0/m1 requester interfaces; ram_* command out, ram_read_data in.
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter bit          FIXED_PRIO    = 1'b0,
   parameter int unsigned RAM_ADDR_BITS = 17
) (
   input  logic              clk,
   input  logic              rst,
   data_ram_arbiter_if.slave m0,
   data_ram_arbiter_if.slave m1,
   output logic              ram_en,
   output logic              ram_write_en,
   output logic [SEL_W-1:0]  ram_write_sel,
   output logic [ADDR_W-1:0] ram_write_addr,
   output logic [DATA_W-1:0] ram_write_data,
   input  logic [DATA_W-1:0] ram_read_data
);

   arb_state_e        state;
   logic              owner;
   logic              last_grant;
   logic              err_q;
   logic [1:0]        grant;
   logic              win;
   logic              w_we;
   logic [SEL_W-1:0]  w_sel;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] rd_capture;

   data_ram_arbiter_rr_arbiter2 u_rr (
      .req        ({m1.req, m0.req}),
      .last_grant (last_grant),
      .fixed_prio (FIXED_PRIO),
      .grant      (grant)
   );

   assign win = grant[1];

   // Fields of the master that wins in IDLE.
   always_comb begin
      w_we    = m0.we;
      w_sel   = m0.sel;
      w_addr  = m0.addr;
      w_wdata = m0.wdata;
      if (win) begin
         w_we    = m1.we;
         w_sel   = m1.sel;
         w_addr  = m1.addr;
         w_wdata = m1.wdata;
      end
   end

   // Only real reads return RAM data; writes and rejected accesses return zero.
   assign rd_capture = (ram_en && !ram_write_en) ? ram_read_data : '0;

   // RAM command is registered at the IDLE->ISSUE edge so it is valid for the
   // whole ISSUE cycle; the response is registered at the ISSUE->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ARB_IDLE;
         owner          <= 1'b0;
         last_grant     <= 1'b1;
         err_q          <= 1'b0;
         ram_en         <= 1'b0;
         ram_write_en   <= 1'b0;
         ram_write_sel  <= '0;
         ram_write_addr <= '0;
         ram_write_data <= '0;
         m0.ready       <= 1'b0;
         m0.err         <= 1'b0;
         m0.rdata       <= '0;
         m1.ready       <= 1'b0;
         m1.err         <= 1'b0;
         m1.rdata       <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|grant) begin
                  owner <= win;
                  state <= ARB_ISSUE;
                  if (addr_in_window(w_addr, RAM_ADDR_BITS)) begin
                     err_q          <= 1'b0;
                     ram_en         <= 1'b1;
                     ram_write_en   <= w_we;
                     ram_write_sel  <= w_we ? w_sel : '0;
                     ram_write_addr <= w_addr;
                     ram_write_data <= w_wdata;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ARB_ISSUE: begin
               ram_en         <= 1'b0;
               ram_write_en   <= 1'b0;
               ram_write_sel  <= '0;
               ram_write_addr <= '0;
               ram_write_data <= '0;
               last_grant     <= owner;
               m0.ready       <= ~owner;
               m0.err         <= ~owner & err_q;
               m0.rdata       <= owner ? '0 : rd_capture;
               m1.ready       <= owner;
               m1.err         <= owner & err_q;
               m1.rdata       <= owner ? rd_capture : '0;
               state          <= ARB_DONE;
            end
            ARB_DONE: begin
               m0.ready <= 1'b0;
               m0.err   <= 1'b0;
               m0.rdata <= '0;
               m1.ready <= 1'b0;
               m1.err   <= 1'b0;
               m1.rdata <= '0;
               state    <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
